// File: rtl/heartbeat_pio_sequencer.sv
// Avalon-MM write master for the heartbeat PIO: a prescaler tick advances the pattern,
// a host override port has priority, and every update is written to PIO register 0.
//
// state | meaning
// IDLE  | no bus cycle; grant host request, else serve a pending tick
// ISSUE | single-cycle write strobe of pattern to PIO register 0
module heartbeat_pio_sequencer #(
    parameter logic [31:0] RESET_PATTERN = 32'h0000_0001,
    parameter int          OVR_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [31:0]      period,
    input  logic [1:0]       mode,
    input  logic             host_req,
    input  logic [31:0]      host_wdata,
    output logic             host_ack,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    output logic [31:0]      pattern,
    output logic [OVR_W-1:0] dropped_ticks
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t      state;
    logic [31:0] count;
    logic [31:0] limit_m1;
    logic        tick;
    logic        tick_eff;
    logic        tick_pending;
    logic        serve_tick;
    logic [31:0] next_pattern;

    // ">=" rather than "==" so a shortened period fires on the next cycle instead of
    // running the counter all the way around.
    assign limit_m1   = (period == 32'd0) ? 32'd0 : period - 32'd1;
    assign tick       = enable && (count >= limit_m1);
    assign tick_eff   = tick && (mode != 2'd3);
    assign serve_tick = (state == IDLE) && !host_req && tick_pending;

    always_comb begin
        next_pattern = pattern;
        case (mode)
            2'd0: next_pattern = pattern ^ 32'd1;
            2'd1: next_pattern = {pattern[31:8],
                                  (pattern[7:0] == 8'h00) ? 8'h01 : {pattern[6:0], pattern[7]}};
            2'd2: next_pattern = pattern + 32'd1;
            default: next_pattern = pattern;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 32'd0;
        end else if (!enable || tick) begin
            count <= 32'd0;
        end else begin
            count <= count + 32'd1;
        end
    end

    // A new tick in the same cycle the old one is served is a fresh pending, not a drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_pending  <= 1'b0;
            dropped_ticks <= '0;
        end else if (!enable) begin
            tick_pending <= 1'b0;
        end else if (tick_eff) begin
            tick_pending <= 1'b1;
            if (tick_pending && !serve_tick && (dropped_ticks != {OVR_W{1'b1}})) begin
                dropped_ticks <= dropped_ticks + 1'b1;
            end
        end else if (serve_tick) begin
            tick_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pattern        <= RESET_PATTERN;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            host_ack       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_req) begin
                        pattern        <= host_wdata;
                        state          <= ISSUE;
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= 1'b0;
                        host_ack       <= 1'b1;
                    end else if (tick_pending) begin
                        pattern        <= next_pattern;
                        state          <= ISSUE;
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= 1'b0;
                        host_ack       <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    pio_chipselect <= 1'b0;
                    pio_write_n    <= 1'b1;
                    host_ack       <= 1'b0;
                end
            endcase
        end
    end

    assign pio_address   = 2'b00;
    assign pio_writedata = pattern;

endmodule

// File: tb/tb_heartbeat_pio_sequencer.sv
// Scoreboard bench for heartbeat_pio_sequencer: a behavioural model predicts each PIO
// write (data, ack, cycle) and the monitor checks every strobe the DUT presents.
module tb_heartbeat_pio_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] period = 32'd4;
    logic [1:0]  mode = 2'd0;
    logic        host_req = 1'b0;
    logic [31:0] host_wdata = 32'd0;
    logic        host_ack;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pattern;
    logic [7:0]  dropped_ticks;

    heartbeat_pio_sequencer #(.RESET_PATTERN(32'h0000_0001), .OVR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .period(period), .mode(mode),
        .host_req(host_req), .host_wdata(host_wdata), .host_ack(host_ack),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
        .pattern(pattern), .dropped_ticks(dropped_ticks)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          host;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   nwrites  = 0;
    int   cyc      = 0;
    int   host_left = 0;
    bit   first_seen = 0;
    int   first_cyc = 0;
    logic [31:0] first_data = 32'd0;

    longint      m_cnt  = 0;
    bit          m_pend = 0;
    bit          m_busy = 0;
    logic [31:0] m_pat  = 32'h0000_0001;
    int          m_drop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] next_pat(input logic [31:0] p, input logic [1:0] m);
        int unsigned b;
        case (m)
            2'd0: return p ^ 32'd1;
            2'd1: begin
                b = p % 256;
                if (b == 0) b = 1;
                else b = ((b * 2) % 256) + (b / 128);
                return (p - (p % 256)) + b;
            end
            2'd2: return p + 32'd1;
            default: return p;
        endcase
    endfunction

    // Reference model, evaluated on the same edge as the DUT with pre-edge inputs.
    task automatic model_step();
        longint lim;
        bit     tick;
        bit     served;
        exp_t   e;
        cyc++;
        if (!reset_n) begin
            m_cnt = 0; m_pend = 0; m_busy = 0; m_pat = 32'h0000_0001; m_drop = 0;
            return;
        end
        lim = (period == 0) ? 1 : longint'(period);
        tick = 0;
        if (enable) begin
            if (m_cnt >= lim - 1) begin tick = 1; m_cnt = 0; end
            else m_cnt++;
        end else begin
            m_cnt = 0;
        end
        served = 0;
        if (m_busy) begin
            m_busy = 0;
        end else if (host_req) begin
            m_pat = host_wdata;
            e.data = m_pat; e.host = 1; e.cyc = cyc;
            exp_q.push_back(e);
            m_busy = 1;
        end else if (m_pend) begin
            m_pat = next_pat(m_pat, mode);
            e.data = m_pat; e.host = 0; e.cyc = cyc;
            exp_q.push_back(e);
            m_busy = 1;
            served = 1;
        end
        if (!enable) m_pend = 0;
        else if (tick && mode != 2'd3) begin
            if (m_pend && !served && m_drop < 255) m_drop++;
            m_pend = 1;
        end else if (served) m_pend = 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (pio_chipselect && !pio_write_n) begin
                    nwrites++;
                    if (!first_seen) begin
                        first_seen = 1; first_cyc = cyc; first_data = pio_writedata;
                    end
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_data", pio_writedata, e.data);
                        chk("wr_ack", host_ack, e.host);
                        chk("wr_cycle", cyc, e.cyc);
                        chk("wr_addr", pio_address, 0);
                    end
                end else begin
                    chk("ack_outside_issue", host_ack, 0);
                    chk("bus_idle", {pio_chipselect, pio_write_n}, 2'b01);
                end
                chk("pattern", pattern, m_pat);
                chk("dropped_ticks", dropped_ticks, m_drop);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (host_req && host_ack) begin
            host_left--;
            if (host_left > 0) host_wdata = $urandom();
            else host_req = 0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int k = 0;
        while (nwrites < target && k < budget) begin step(); k++; end
        chk(name, nwrites >= target, 1);
    endtask

    task automatic host_write(input logic [31:0] d);
        int k = 0;
        host_wdata = d; host_left = 1; host_req = 1;
        while (host_req && k < 30) begin step(); k++; end
        chk("host_write_timeout", host_req, 0);
    endtask

    initial begin : main
        int n0;
        int rel0;
        int k;
        #2 reset_n = 0;
        #1;
        chk("rst_cs", pio_chipselect, 0);
        chk("rst_write_n", pio_write_n, 1);
        chk("rst_addr", pio_address, 0);
        chk("rst_ack", host_ack, 0);
        chk("rst_pattern", pattern, 32'h0000_0001);
        chk("rst_dropped", dropped_ticks, 0);

        enable = 1; period = 4; mode = 0;
        steps(3);
        reset_n = 1;
        rel0 = cyc;
        wait_writes(1, 20, "first_write_timeout");
        chk("first_strobe_cycle", first_cyc - rel0, 5);
        chk("first_strobe_data", first_data, 32'h0000_0000);
        steps(20);

        enable = 0; mode = 1;
        steps(3);
        host_write(32'h0000_0180);
        chk("mode1_host_pattern", pattern, 32'h0000_0180);
        n0 = nwrites;
        enable = 1; period = 4;
        wait_writes(n0 + 2, 30, "mode1_timeout");
        enable = 0;
        chk("mode1_two_rotations", pattern, 32'h0000_0102);
        steps(3);
        host_write(32'h0000_0A00);
        n0 = nwrites;
        enable = 1;
        wait_writes(n0 + 1, 30, "mode1_zero_timeout");
        enable = 0;
        chk("mode1_zero_byte", pattern, 32'h0000_0A01);

        steps(3);
        mode = 2;
        host_write(32'hFFFF_FFFF);
        n0 = nwrites;
        enable = 1; period = 3;
        wait_writes(n0 + 1, 30, "mode2_timeout");
        enable = 0;
        chk("mode2_wrap", pattern, 32'h0000_0000);

        steps(3);
        mode = 0; period = 1; enable = 1;
        host_wdata = $urandom(); host_left = 3; host_req = 1;
        k = 0;
        while (host_req && k < 30) begin step(); k++; end
        chk("host_hold_timeout", host_req, 0);
        steps(6);
        host_wdata = $urandom(); host_left = 150; host_req = 1;
        k = 0;
        while (host_req && k < 400) begin step(); k++; end
        chk("long_hold_timeout", host_req, 0);
        chk("dropped_saturated", dropped_ticks, 8'hFF);
        steps(4);

        n0 = nwrites;
        period = 0; mode = 2;
        steps(12);
        chk("period0_writes", (nwrites - n0) >= 4, 1);

        enable = 0;
        steps(3);
        n0 = nwrites;
        mode = 0; period = 10; enable = 1;
        steps(5);
        enable = 0;
        steps(20);
        chk("enable_low_no_write", nwrites, n0);

        n0 = nwrites;
        mode = 3; period = 2; enable = 1;
        steps(30);
        chk("mode3_no_write", nwrites, n0);
        chk("mode3_no_drop", dropped_ticks, 8'hFF);

        for (int i = 0; i < 800; i++) begin
            step();
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            if ($urandom_range(0, 15) == 0) period = $urandom_range(0, 6);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if (!host_req && $urandom_range(0, 5) == 0) begin
                host_wdata = $urandom(); host_left = $urandom_range(1, 3); host_req = 1;
            end
        end
        k = 0;
        while (host_req && k < 30) begin step(); k++; end
        chk("random_drain_timeout", host_req, 0);

        enable = 0;
        steps(3);
        host_wdata = $urandom(); host_left = 1; host_req = 1;
        @(posedge clk);
        #1;
        chk("issue_started", pio_chipselect, 1);
        reset_n = 0;
        #1;
        chk("midissue_cs", pio_chipselect, 0);
        chk("midissue_write_n", pio_write_n, 1);
        chk("midissue_ack", host_ack, 0);
        chk("midissue_pattern", pattern, 32'h0000_0001);
        chk("midissue_dropped", dropped_ticks, 0);
        host_req = 0; host_left = 0;
        @(negedge clk);
        exp_q.delete();
        steps(2);
        reset_n = 1;
        n0 = nwrites;
        steps(6);
        chk("no_write_on_release", nwrites, n0);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
